control_sequencer: RTL and testbench

Parametrised next-generation control unit for the Harvard, non-pipelined CPU. It owns the fetch/exec1/exec2 sequencer internally and latches the opcode into an instruction register. It decodes the same instruction set into datapath strobes. Over the previous combinational decoder it adds a memory-ready stall handshake, halt/restart, and a tracked call-stack depth with overflow/underflow fault detection.

---
 rtl/control_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/exec1/exec2 control unit for the Harvard,
// non-pipelined CPU. Latches the opcode, decodes it into datapath strobes,
// stalls on data-memory ready, supports halt/restart and tracks call-stack
// depth with sticky overflow/underflow/illegal-opcode fault.
module control_sequencer #(
  parameter int OP_W        = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] inst,
  input  logic            eq,
  input  logic            mem_ready,
  input  logic            run,
  output logic [2:0]      state,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            stack_mux,
  output logic            push,
  output logic            pop,
  output logic            WrEn,
  output logic            e,
  output logic            acc_load,
  output logic            halted,
  output logic            fault,
  output logic [SP_W-1:0] sp_level
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALT,
    S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_JEQ,
    OP_STA,
    OP_JMP,
    OP_STP,
    OP_LDA,
    OP_JMS,
    OP_BBL,
    OP_LDR
  } op_t;

  state_t          cur;
  logic [OP_W-1:0] ir;
  op_t             op;
  logic            illegal;
  logic            overflow;
  logic            underflow;
  logic            stack_err;

  // Any set bit above the 4-bit opcode field makes the instruction illegal.
  if (OP_W > 4) begin : g_hi
    assign illegal = |ir[OP_W-1:4];
  end else begin : g_no_hi
    assign illegal = 1'b0;
  end

  // Decode the low opcode field of the instruction register.
  always_comb begin
    op = OP_NOP;
    casez (ir[3:0])
      4'b000?: op = OP_JEQ;
      4'b0010: op = OP_STA;
      4'b0011: op = OP_JMP;
      4'b0100: op = OP_STP;
      4'b0101: op = OP_LDA;
      4'b0110: op = OP_JMS;
      4'b0111: op = OP_BBL;
      4'b1110: op = OP_LDR;
      default: op = OP_NOP;
    endcase
  end

  assign overflow  = (op == OP_JMS) && (sp_level == SP_W'(STACK_DEPTH));
  assign underflow = (op == OP_BBL) && (sp_level == '0);
  assign stack_err = overflow || underflow;

  // One-hot phase indication; HALT and FAULT both read as all-zero.
  always_comb begin
    state = 3'b000;
    case (cur)
      S_FETCH: state = 3'b001;
      S_EXEC1: state = 3'b010;
      S_EXEC2: state = 3'b100;
      default: state = 3'b000;
    endcase
  end

  // Datapath strobes from current phase, latched opcode and live flags.
  always_comb begin
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    stack_mux = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    WrEn      = 1'b0;
    e         = 1'b0;
    acc_load  = 1'b0;
    if (cur == S_EXEC1 && !illegal && !stack_err) begin
      case (op)
        OP_JMP: pc_load = 1'b1;
        OP_JEQ: begin
          pc_load = !eq;
          pc_inc  = eq;
        end
        OP_JMS: begin
          push    = 1'b1;
          pc_load = 1'b1;
        end
        OP_BBL: begin
          pop       = 1'b1;
          pc_load   = 1'b1;
          stack_mux = 1'b1;
        end
        OP_STA: begin
          WrEn   = 1'b1;
          pc_inc = mem_ready;
        end
        OP_LDA, OP_LDR: begin
          e      = 1'b1;
          pc_inc = 1'b1;
        end
        OP_STP:  ;
        default: pc_inc = 1'b1;
      endcase
    end else if (cur == S_EXEC2) begin
      e        = 1'b1;
      acc_load = mem_ready;
    end
  end

  // Sequencer, instruction register, stack depth and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= S_FETCH;
      ir       <= '0;
      sp_level <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          ir  <= inst;
          cur <= S_EXEC1;
        end
        S_EXEC1: begin
          if (illegal || stack_err) begin
            fault <= 1'b1;
            cur   <= S_FAULT;
          end else begin
            case (op)
              OP_LDA, OP_LDR: cur <= S_EXEC2;
              OP_STP: begin
                halted <= 1'b1;
                cur    <= S_HALT;
              end
              OP_STA: if (mem_ready) cur <= S_FETCH;
              OP_JMS: begin
                sp_level <= sp_level + SP_W'(1);
                cur      <= S_FETCH;
              end
              OP_BBL: begin
                sp_level <= sp_level - SP_W'(1);
                cur      <= S_FETCH;
              end
              default: cur <= S_FETCH;
            endcase
          end
        end
        S_EXEC2: if (mem_ready) cur <= S_FETCH;
        S_HALT: begin
          if (run) begin
            halted <= 1'b0;
            cur    <= S_FETCH;
          end
        end
        S_FAULT: cur <= S_FAULT;
        default: cur <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer (OP_W=6, STACK_DEPTH=2).
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] inst;
  logic       eq, mem_ready, run;
  logic [2:0] state;
  logic       pc_inc, pc_load, stack_mux, push, pop, WrEn, e, acc_load;
  logic       halted, fault;
  logic [1:0] sp_level;

  int checks   = 0;
  int failures = 0;

  control_sequencer #(.OP_W(6), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .eq(eq), .mem_ready(mem_ready),
    .run(run), .state(state), .pc_inc(pc_inc), .pc_load(pc_load),
    .stack_mux(stack_mux), .push(push), .pop(pop), .WrEn(WrEn), .e(e),
    .acc_load(acc_load), .halted(halted), .fault(fault), .sp_level(sp_level)
  );

  always #5 clk = ~clk;

  // strobe order: pc_inc pc_load stack_mux push pop WrEn e acc_load
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] INC  = 8'b1000_0000;
  localparam logic [7:0] LD   = 8'b0100_0000;
  localparam logic [7:0] LDA1 = 8'b1000_0010;
  localparam logic [7:0] EONL = 8'b0000_0010;
  localparam logic [7:0] EACC = 8'b0000_0011;
  localparam logic [7:0] STA0 = 8'b0000_0100;
  localparam logic [7:0] STA1 = 8'b1000_0100;
  localparam logic [7:0] JMS  = 8'b0101_0000;
  localparam logic [7:0] BBL  = 8'b0110_1000;

  localparam logic [5:0] I_NOP = 6'b001000;
  localparam logic [5:0] I_JEQ = 6'b000000;
  localparam logic [5:0] I_JE1 = 6'b000001;
  localparam logic [5:0] I_STA = 6'b000010;
  localparam logic [5:0] I_STP = 6'b000100;
  localparam logic [5:0] I_LDA = 6'b000101;
  localparam logic [5:0] I_JMS = 6'b000110;
  localparam logic [5:0] I_BBL = 6'b000111;
  localparam logic [5:0] I_ILL = 6'b010011;

  typedef struct {
    string      name;
    logic [5:0] inst;
    logic       eq;
    logic       mr;
    logic       run;
    logic [2:0] st;
    logic [7:0] strb;
    logic       hlt;
    logic       flt;
    logic [1:0] sp;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [5:0] i,
                              input logic q, input logic m, input logic r,
                              input logic [2:0] s, input logic [7:0] b,
                              input logic h, input logic f,
                              input logic [1:0] p);
    vec_t v;
    v.name = n; v.inst = i; v.eq = q; v.mr = m; v.run = r;
    v.st = s; v.strb = b; v.hlt = h; v.flt = f; v.sp = p;
    return v;
  endfunction

  task automatic check_now(input vec_t v);
    logic [14:0] act, exp;
    act = {state, pc_inc, pc_load, stack_mux, push, pop, WrEn, e, acc_load,
           halted, fault, sp_level};
    exp = {v.st, v.strb, v.hlt, v.flt, v.sp};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%b strb=%b h=%b f=%b sp=%0d, want st=%b strb=%b h=%b f=%b sp=%0d",
               v.name, act[14:12], act[11:4], act[3], act[2], act[1:0],
               exp[14:12], exp[11:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance a clock.
  task automatic run_vec(input vec_t v);
    inst = v.inst; eq = v.eq; mem_ready = v.mr; run = v.run;
    #1;
    check_now(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string n);
    rst_n = 1'b0;
    inst = '0; eq = 1'b0; mem_ready = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now(mk(n, '0, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk("nop_fetch",   I_NOP, 0, 1, 0, 3'b001, NONE, 0, 0, 2'd0));
    tbl.push_back(mk("nop_exec1",   I_NOP, 0, 1, 0, 3'b010, INC,  0, 0, 2'd0));
    tbl.push_back(mk("lda_fetch",   I_LDA, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    tbl.push_back(mk("lda_exec1",   I_LDA, 0, 0, 0, 3'b010, LDA1, 0, 0, 2'd0));
    tbl.push_back(mk("lda_stall1",  I_LDA, 0, 0, 0, 3'b100, EONL, 0, 0, 2'd0));
    tbl.push_back(mk("lda_stall2",  I_LDA, 0, 0, 0, 3'b100, EONL, 0, 0, 2'd0));
    tbl.push_back(mk("lda_stall3",  I_LDA, 0, 0, 0, 3'b100, EONL, 0, 0, 2'd0));
    tbl.push_back(mk("lda_done",    I_LDA, 0, 1, 0, 3'b100, EACC, 0, 0, 2'd0));
    tbl.push_back(mk("jeq0_fetch",  I_JEQ, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    tbl.push_back(mk("jeq0_exec1",  I_JEQ, 0, 0, 0, 3'b010, LD,   0, 0, 2'd0));
    tbl.push_back(mk("jeq1_fetch",  I_JE1, 1, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    tbl.push_back(mk("jeq1_exec1",  I_JE1, 1, 0, 0, 3'b010, INC,  0, 0, 2'd0));
    tbl.push_back(mk("sta_fetch",   I_STA, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    tbl.push_back(mk("sta_stall1",  I_STA, 0, 0, 0, 3'b010, STA0, 0, 0, 2'd0));
    tbl.push_back(mk("sta_stall2",  I_STA, 0, 0, 0, 3'b010, STA0, 0, 0, 2'd0));
    tbl.push_back(mk("sta_done",    I_STA, 0, 1, 0, 3'b010, STA1, 0, 0, 2'd0));
    tbl.push_back(mk("jms1_fetch",  I_JMS, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    tbl.push_back(mk("jms1_exec1",  I_JMS, 0, 0, 0, 3'b010, JMS,  0, 0, 2'd0));
    tbl.push_back(mk("jms2_fetch",  I_JMS, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd1));
    tbl.push_back(mk("jms2_exec1",  I_JMS, 0, 0, 0, 3'b010, JMS,  0, 0, 2'd1));
    tbl.push_back(mk("bbl_fetch",   I_BBL, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd2));
    tbl.push_back(mk("bbl_exec1",   I_BBL, 0, 0, 0, 3'b010, BBL,  0, 0, 2'd2));
    tbl.push_back(mk("jms3_fetch",  I_JMS, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd1));
    tbl.push_back(mk("jms3_exec1",  I_JMS, 0, 0, 0, 3'b010, JMS,  0, 0, 2'd1));
    tbl.push_back(mk("jms4_fetch",  I_JMS, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd2));
    tbl.push_back(mk("ovf_exec1",   I_JMS, 0, 0, 0, 3'b010, NONE, 0, 0, 2'd2));
    tbl.push_back(mk("ovf_fault",   I_JMS, 0, 1, 1, 3'b000, NONE, 0, 1, 2'd2));
    tbl.push_back(mk("fault_run",   I_NOP, 0, 1, 1, 3'b000, NONE, 0, 1, 2'd2));
    tbl.push_back(mk("fault_hold",  I_NOP, 0, 1, 0, 3'b000, NONE, 0, 1, 2'd2));

    do_reset("reset_main");
    foreach (tbl[k]) run_vec(tbl[k]);

    // Underflow: BBL with an empty stack faults without popping.
    do_reset("reset_clears_fault");
    run_vec(mk("unf_fetch", I_BBL, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    run_vec(mk("unf_exec1", I_BBL, 0, 0, 0, 3'b010, NONE, 0, 0, 2'd0));
    run_vec(mk("unf_fault", I_NOP, 0, 0, 1, 3'b000, NONE, 0, 1, 2'd0));

    // Halt, ignored idle run, then restart into FETCH.
    do_reset("reset_stp");
    run_vec(mk("stp_fetch", I_STP, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    run_vec(mk("stp_exec1", I_STP, 0, 0, 0, 3'b010, NONE, 0, 0, 2'd0));
    for (int c = 0; c < 5; c++)
      run_vec(mk("halt_hold", I_NOP, 0, 1, 0, 3'b000, NONE, 1, 0, 2'd0));
    run_vec(mk("halt_run",   I_NOP, 0, 0, 1, 3'b000, NONE, 1, 0, 2'd0));
    run_vec(mk("rst_fetch",  I_NOP, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    run_vec(mk("rst_exec1",  I_NOP, 0, 0, 1, 3'b010, INC,  0, 0, 2'd0));

    // Non-zero upper opcode bits are illegal even with a valid low field.
    do_reset("reset_ill");
    run_vec(mk("ill_fetch", I_ILL, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    run_vec(mk("ill_exec1", I_ILL, 0, 0, 0, 3'b010, NONE, 0, 0, 2'd0));
    run_vec(mk("ill_fault", I_NOP, 0, 0, 0, 3'b000, NONE, 0, 1, 2'd0));

    // Asynchronous reset during a stalled store aborts the write strobe.
    do_reset("reset_sta");
    run_vec(mk("sta_f",   I_STA, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    run_vec(mk("sta_e1",  I_STA, 0, 0, 0, 3'b010, STA0, 0, 0, 2'd0));
    rst_n = 1'b0;
    #1;
    check_now(mk("sta_abort", I_STA, 0, 0, 0, 3'b001, NONE, 0, 0, 2'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(mk("post_fetch", I_NOP, 0, 1, 0, 3'b001, NONE, 0, 0, 2'd0));
    run_vec(mk("post_exec1", I_NOP, 0, 1, 0, 3'b010, INC,  0, 0, 2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
